// File: rtl/rand_bcd_display.sv
// Rolls a random byte on a debounced key press, converts it to BCD with a
// sequential double-dabble engine and drives three blanked seven-segment digits.
module rand_bcd_display #(
    parameter int unsigned DB_CYCLES      = 16,
    parameter bit          SEG_ACTIVE_LOW = 1'b1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        key,
    input  logic [7:0]  rnd_in,
    output logic [7:0]  value,
    output logic [11:0] bcd,
    output logic [6:0]  seg2,
    output logic [6:0]  seg1,
    output logic [6:0]  seg0,
    output logic        busy,
    output logic        done
);

    localparam int unsigned CNT_W     = $clog2(DB_CYCLES + 1);
    localparam logic [6:0]  SEG_INV   = SEG_ACTIVE_LOW ? 7'h00 : 7'h7F;
    localparam logic [6:0]  SEG_BLANK = 7'h7F ^ SEG_INV;

    typedef enum logic {S_IDLE, S_CONV} state_t;

    state_t             state_q, state_d;
    logic               sync1_q, sync2_q;
    logic               key_db_q, key_db_d;
    logic               key_db_d_q;
    logic [CNT_W-1:0]   db_cnt_q, db_cnt_d;
    logic [7:0]         bin_q, bin_d;
    logic [11:0]        scratch_q, scratch_d;
    logic [2:0]         iter_q, iter_d;
    logic [7:0]         value_q, value_d;
    logic [11:0]        bcd_q, bcd_d;
    logic [6:0]         seg2_q, seg2_d, seg1_q, seg1_d, seg0_q, seg0_d;
    logic               busy_q, busy_d, done_q, done_d;
    logic               press;
    logic [11:0]        adj;
    logic [11:0]        scratch_sh;
    logic [7:0]         bin_sh;

    // Active-low gfedcba code for one digit, polarity applied afterwards
    function automatic logic [6:0] seg_code(input logic [3:0] d);
        logic [6:0] c;
        case (d)
            4'd0:    c = 7'h40;
            4'd1:    c = 7'h79;
            4'd2:    c = 7'h24;
            4'd3:    c = 7'h30;
            4'd4:    c = 7'h19;
            4'd5:    c = 7'h12;
            4'd6:    c = 7'h02;
            4'd7:    c = 7'h78;
            4'd8:    c = 7'h00;
            4'd9:    c = 7'h10;
            default: c = 7'h7F;
        endcase
        return c ^ SEG_INV;
    endfunction

    assign press = key_db_q & ~key_db_d_q;

    always_comb begin
        adj[11:8] = (scratch_q[11:8] >= 4'd5) ? scratch_q[11:8] + 4'd3 : scratch_q[11:8];
        adj[7:4]  = (scratch_q[7:4]  >= 4'd5) ? scratch_q[7:4]  + 4'd3 : scratch_q[7:4];
        adj[3:0]  = (scratch_q[3:0]  >= 4'd5) ? scratch_q[3:0]  + 4'd3 : scratch_q[3:0];
        scratch_sh = {adj[10:0], bin_q[7]};
        bin_sh     = {bin_q[6:0], 1'b0};
    end

    // Debounce: key_db follows sync2 only after DB_CYCLES consecutive differing cycles
    always_comb begin
        key_db_d = key_db_q;
        db_cnt_d = '0;
        if (sync2_q != key_db_q) begin
            if (db_cnt_q == CNT_W'(DB_CYCLES - 1)) begin
                key_db_d = sync2_q;
            end else begin
                db_cnt_d = db_cnt_q + CNT_W'(1);
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        bin_d     = bin_q;
        scratch_d = scratch_q;
        iter_d    = iter_q;
        value_d   = value_q;
        bcd_d     = bcd_q;
        seg2_d    = seg2_q;
        seg1_d    = seg1_q;
        seg0_d    = seg0_q;
        busy_d    = 1'b0;
        done_d    = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (press) begin
                    value_d   = rnd_in;
                    bin_d     = rnd_in;
                    scratch_d = '0;
                    iter_d    = '0;
                    busy_d    = 1'b1;
                    state_d   = S_CONV;
                end
            end
            S_CONV: begin
                bin_d     = bin_sh;
                scratch_d = scratch_sh;
                iter_d    = iter_q + 3'd1;
                busy_d    = 1'b1;
                if (iter_q == 3'd7) begin
                    bcd_d   = scratch_sh;
                    seg2_d  = (scratch_sh[11:8] == 4'd0) ? SEG_BLANK : seg_code(scratch_sh[11:8]);
                    seg1_d  = (scratch_sh[11:4] == 8'd0) ? SEG_BLANK : seg_code(scratch_sh[7:4]);
                    seg0_d  = seg_code(scratch_sh[3:0]);
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= S_IDLE;
            sync1_q    <= 1'b0;
            sync2_q    <= 1'b0;
            key_db_q   <= 1'b0;
            key_db_d_q <= 1'b0;
            db_cnt_q   <= '0;
            bin_q      <= '0;
            scratch_q  <= '0;
            iter_q     <= '0;
            value_q    <= '0;
            bcd_q      <= '0;
            seg2_q     <= SEG_BLANK;
            seg1_q     <= SEG_BLANK;
            seg0_q     <= SEG_BLANK;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            sync1_q    <= key;
            sync2_q    <= sync1_q;
            key_db_q   <= key_db_d;
            key_db_d_q <= key_db_q;
            db_cnt_q   <= db_cnt_d;
            bin_q      <= bin_d;
            scratch_q  <= scratch_d;
            iter_q     <= iter_d;
            value_q    <= value_d;
            bcd_q      <= bcd_d;
            seg2_q     <= seg2_d;
            seg1_q     <= seg1_d;
            seg0_q     <= seg0_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    assign value = value_q;
    assign bcd   = bcd_q;
    assign seg2  = seg2_q;
    assign seg1  = seg1_q;
    assign seg0  = seg0_q;
    assign busy  = busy_q;
    assign done  = done_q;

endmodule

// File: tb/tb_rand_bcd_display.sv
// Scoreboard bench for rand_bcd_display: expected results queued at press time,
// compared whenever the display reports a finished conversion.
module tb_rand_bcd_display;

    localparam int unsigned DB = 16;

    typedef struct packed {
        logic [7:0]  v;
        logic [11:0] b;
        logic [20:0] s;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        key = 1'b0, key2 = 1'b0;
    logic [7:0]  rnd_in = 8'd0, rnd2 = 8'd0;
    logic [7:0]  value, value2;
    logic [11:0] bcd, bcd2;
    logic [6:0]  seg2, seg1, seg0, s2b, s1b, s0b;
    logic        busy, done, busy2, done2;

    int   n_checks = 0;
    int   n_errors = 0;
    int   n_done   = 0;
    int   n_pushed = 0;
    exp_t sb_q[$];

    always #5 clk = ~clk;

    rand_bcd_display #(.DB_CYCLES(DB), .SEG_ACTIVE_LOW(1'b1)) dut (
        .clk(clk), .reset(reset), .key(key), .rnd_in(rnd_in),
        .value(value), .bcd(bcd), .seg2(seg2), .seg1(seg1), .seg0(seg0),
        .busy(busy), .done(done)
    );

    rand_bcd_display #(.DB_CYCLES(2), .SEG_ACTIVE_LOW(1'b1)) dut2 (
        .clk(clk), .reset(reset), .key(key2), .rnd_in(rnd2),
        .value(value2), .bcd(bcd2), .seg2(s2b), .seg1(s1b), .seg0(s0b),
        .busy(busy2), .done(done2)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [6:0] ref_seg(input int d);
        case (d)
            0: return 7'h40;  1: return 7'h79;  2: return 7'h24;  3: return 7'h30;
            4: return 7'h19;  5: return 7'h12;  6: return 7'h02;  7: return 7'h78;
            8: return 7'h00;  9: return 7'h10;
            default: return 7'h7F;
        endcase
    endfunction

    function automatic exp_t model(input logic [7:0] v);
        exp_t e;
        int h, t, o;
        h = int'(v) / 100;
        t = (int'(v) / 10) % 10;
        o = int'(v) % 10;
        e.v = v;
        e.b = {4'(h), 4'(t), 4'(o)};
        e.s = {(h == 0) ? 7'h7F : ref_seg(h),
               (h == 0 && t == 0) ? 7'h7F : ref_seg(t),
               ref_seg(o)};
        return e;
    endfunction

    // Every done pulse must match the oldest outstanding expectation
    always @(negedge clk) begin
        if (done) begin
            exp_t e;
            n_done++;
            if (sb_q.size() == 0) begin
                check("unexpected_done", 32'(bcd), 32'hFFFF_FFFF);
            end else begin
                e = sb_q.pop_front();
                check("value", 32'(value), 32'(e.v));
                check("bcd", 32'(bcd), 32'(e.b));
                check("segs", 32'({seg2, seg1, seg0}), 32'(e.s));
                check("busy_at_done", 32'(busy), 32'd0);
            end
        end
    end

    task automatic push_exp(input logic [7:0] v);
        sb_q.push_back(model(v));
        n_pushed++;
    endtask

    task automatic press(input logic [7:0] v);
        rnd_in = v;
        push_exp(v);
        @(negedge clk) key = 1'b1;
        repeat (40) @(negedge clk);
        key = 1'b0;
        repeat (40) @(negedge clk);
    endtask

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin : main
        int c_edge, d_edge, done_before;
        logic saw_busy;
        int d2_cnt;
        logic [11:0] bcd2_seen;
        logic [7:0]  val2_seen;

        repeat (3) @(posedge clk);
        #1;
        check("rst_value", 32'(value), 32'h00);
        check("rst_bcd", 32'(bcd), 32'h000);
        check("rst_segs", 32'({seg2, seg1, seg0}), 32'({7'h7F, 7'h7F, 7'h7F}));
        check("rst_busy_done", 32'({busy, done}), 32'd0);
        @(negedge clk) reset = 1'b1;
        repeat (20) @(negedge clk);
        check("idle_value", 32'(value), 32'h00);
        check("idle_segs", 32'({seg2, seg1, seg0}), 32'({7'h7F, 7'h7F, 7'h7F}));
        check("idle_busy_done", 32'({busy, done}), 32'd0);

        // Latency: key rises before edge N, capture at N+DB+2, done after N+DB+10
        rnd_in = 8'd255;
        push_exp(8'd255);
        done_before = n_done;
        @(negedge clk) key = 1'b1;
        c_edge = 0;
        d_edge = 0;
        for (int k = 0; k < 70; k++) begin
            @(posedge clk);
            #1;
            if (busy && c_edge == 0) c_edge = k;
            if (done && d_edge == 0) d_edge = k;
            if (k == 39) key = 1'b0;
        end
        check("capture_edge", 32'(c_edge), 32'(DB + 2));
        check("done_edge", 32'(d_edge), 32'(DB + 10));
        repeat (30) @(negedge clk);
        check("single_done_255", 32'(n_done - done_before), 32'd1);

        press(8'd7);
        press(8'd100);

        // Glitch shorter than the debounce window
        done_before = n_done;
        saw_busy = 1'b0;
        @(negedge clk) key = 1'b1;
        repeat (DB - 1) @(negedge clk);
        key = 1'b0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            saw_busy |= busy;
        end
        check("glitch_busy", 32'(saw_busy), 32'd0);
        check("glitch_done", 32'(n_done - done_before), 32'd0);

        // Bouncy contact settles high: one capture
        done_before = n_done;
        rnd_in = 8'd59;
        push_exp(8'd59);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk) key = ~k[0];
            @(negedge clk);
        end
        key = 1'b1;
        repeat (60) @(negedge clk);
        key = 1'b0;
        repeat (40) @(negedge clk);
        check("bounce_done", 32'(n_done - done_before), 32'd1);

        // Re-press whose press pulse lands during CONV (fast-debounce instance)
        rnd2 = 8'd123;
        @(negedge clk) key2 = 1'b1;
        repeat (5) @(posedge clk);
        @(negedge clk) key2 = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk) begin
            key2 = 1'b1;
            rnd2 = 8'd9;
        end
        d2_cnt = 0;
        bcd2_seen = '0;
        val2_seen = '0;
        for (int k = 0; k < 40; k++) begin
            @(posedge clk);
            #1;
            if (done2) begin
                d2_cnt++;
                bcd2_seen = bcd2;
                val2_seen = value2;
            end
        end
        check("conv_press_dones", 32'(d2_cnt), 32'd1);
        check("conv_press_bcd", 32'(bcd2_seen), 32'h123);
        check("conv_press_value", 32'(val2_seen), 32'd123);
        check("conv_press_hold", 32'(bcd2), 32'h123);
        key2 = 1'b0;

        // Reset four edges into a conversion
        done_before = n_done;
        rnd_in = 8'd200;
        @(negedge clk) key = 1'b1;
        c_edge = -1;
        for (int k = 0; k < 60 && c_edge < 0; k++) begin
            @(posedge clk);
            #1;
            if (busy) c_edge = k;
        end
        check("mid_conv_started", 32'(c_edge >= 0), 32'd1);
        repeat (4) @(posedge clk);
        #1;
        reset = 1'b0;
        key = 1'b0;
        #1;
        check("midrst_busy_done", 32'({busy, done}), 32'd0);
        check("midrst_value", 32'(value), 32'h00);
        check("midrst_bcd", 32'(bcd), 32'h000);
        check("midrst_segs", 32'({seg2, seg1, seg0}), 32'({7'h7F, 7'h7F, 7'h7F}));
        repeat (3) @(negedge clk);
        reset = 1'b1;
        repeat (40) @(negedge clk);
        check("midrst_no_done", 32'(n_done - done_before), 32'd0);
        check("midrst_still_blank", 32'({seg2, seg1, seg0}), 32'({7'h7F, 7'h7F, 7'h7F}));

        press(8'd42);
        for (int k = 0; k < 4; k++) press(8'($urandom_range(0, 255)));

        check("sb_empty", 32'(sb_q.size()), 32'd0);
        check("done_total", 32'(n_done), 32'(n_pushed));

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/rand_bcd_display.md
# rand_bcd_display

Downstream consumer of the 8-bit pseudo-random generator: on a debounced key press it captures the current random byte, converts it to three BCD digits with a sequential shift-add-3 (double-dabble) engine, and drives three seven-segment digits with leading-zero blanking. It sits between the LFSR output bus and the board's digit pins, giving the "roll a random number" demo its user-visible result.

## Interface
- DB_CYCLES, 16: consecutive stable cycles required before the debounced key changes state (≥2).
- SEG_ACTIVE_LOW, 1: 1 means segment pins are active-low; 0 inverts all seg outputs, including blank.
- clk  in  1  rising-edge clock, single clock domain.
- reset  in  1  asynchronous, active-low reset: 0 resets immediately, release is synchronous to clk.
- key  in  1  raw push-button, active-high, asynchronous to clk.
- rnd_in  in  8  current random byte from the LFSR.
- value  out  8  captured byte; reset 8'h00.
- bcd  out  12  {hundreds, tens, ones} of value; reset 12'h000.
- seg2, seg1, seg0  out  7 each  hundreds, tens, ones digit, bit order {g,f,e,d,c,b,a}; reset blank.
- busy  out  1  high while converting; reset 0.
- done  out  1  one-cycle pulse when bcd/seg update; reset 0.

## Operation
- key passes through a 2-flop synchronizer (sync1, sync2).
- Debounce: counter clears whenever sync2 equals key_db. While they differ it increments; when it has counted DB_CYCLES differing cycles, key_db takes sync2 and the counter clears.
- press = key_db rising edge, registered against key_db_d, so it lasts one cycle.
- FSM states:
  - IDLE: busy=0. On press, capture rnd_in into value and into the shift register, clear the BCD scratch, set iteration count=0, and go to CONV.
  - CONV: busy=1. Each cycle, add 3 to every scratch nibble ≥5, then shift {scratch, binary} left 1. After the 8th iteration, load bcd and segments, pulse done, and return to IDLE.
- A press while in CONV is dropped, not queued. Holding the key gives exactly one capture. Release needs DB_CYCLES stable cycles before another press can register.
- Segment codes when active-low (hex, gfedcba):
  - 0=40, 1=79, 2=24, 3=30, 4=19
  - 5=12, 6=02, 7=78, 8=00, 9=10
  - blank=7F
  - When SEG_ACTIVE_LOW=0, every code is bitwise inverted.
- Blanking rules:
  - seg2 is blank if hundreds=0.
  - seg1 is blank if hundreds=0 and tens=0.
  - seg0 always shows a digit.
- value, bcd and segs hold their last result until the next completed conversion.
- reset low in any state, including mid-CONV: all state and outputs return to reset values at once, and a partial result is never shown.

## Timing
- Let key rise before edge N, held stable.
  - sync1 captures it at edge N; sync2 at edge N+1.
  - key_db sets at edge N+1+DB_CYCLES.
  - Capture edge C = N+2+DB_CYCLES; rnd_in is sampled at C.
- busy is high from after C until after C+8.
- bcd and seg are updated at edge C+8. done is high for the cycle following C+8 only.
- Press-to-display latency is DB_CYCLES+10 edges. Throughput is at most one conversion per 9 cycles, further limited by debounce.
- A key pulse shorter than DB_CYCLES cycles after sync2 produces no press.

## Test plan
- Reset: hold reset=0 for 3 cycles → value=00, bcd=000, seg2/seg1/seg0=7F, busy=0, done=0; all still hold after release with no key activity.
- rnd_in=8'd255, press key for 40 cycles with DB_CYCLES=16 → capture at edge N+18, done at N+26, bcd=12'h255, seg2=24, seg1=12, seg0=12; exactly one done.
- rnd_in=8'd7 → bcd=12'h007, seg2=7F, seg1=7F, seg0=78. rnd_in=8'd100 → bcd=12'h100, seg2=79, seg1=40, seg0=40.
- key high for DB_CYCLES−1 cycles, then low → no capture, busy stays 0. Bounce pattern 1-0-1-0 at 2-cycle spacing, then stable high → one capture.
- Second clean press whose press pulse lands during CONV → ignored; result matches the first capture only, single done.
- reset=0 at C+4 → busy=0 and outputs at reset values immediately. After release, a new press with rnd_in=8'd42 → bcd=12'h042, seg2=7F, seg1=19, seg0=24.
